okwo_event_status: RTL and testbench

- Upstream feeder for a Wire Out endpoint.
- Turns user-side event pulses into a sticky event word plus a saturating event-cycle counter and an overflow flag, presented as one registered 32-bit status word on ep_datain.
- Implements lossless clear-on-read: at the host wire-update edge, only what the host was shown is cleared. Events arriving during the read are kept for the next read.

---
 rtl/okwo_status_pkg.sv | 26 ++
 rtl/okwo_sat_counter.sv | 61 ++++++
 rtl/okwo_event_status.sv | 87 ++++++++
 tb/tb_okwo_event_status.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/okwo_status_pkg.sv
// Shared field layout, counter update modes and saturating arithmetic for the
// okwo event-status Wire Out feeder.
package okwo_status_pkg;

  localparam int unsigned STATUS_W = 32;
  localparam int unsigned OVF_BIT  = 31;
  localparam int unsigned CNT_H    = 30;
  localparam int unsigned CNT_L    = 16;
  localparam int unsigned STK_H    = 15;
  localparam int unsigned STK_L    = 0;

  typedef enum logic [1:0] {
    ModeHold  = 2'd0,
    ModeRead  = 2'd1,
    ModeClear = 2'd2
  } cnt_mode_e;

  // a - b + inc, clamped at max_val; callers guarantee a >= b.
  function automatic logic [31:0] sat_add_sub(input logic [31:0] a, input logic [31:0] b,
                                              input logic inc, input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a - b} + 33'(inc);
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage

// File: rtl/okwo_sat_counter.sv
// Saturating event-cycle counter with subtract-reported, clear and a sticky
// overflow flag; exposes both current and next state.
module okwo_sat_counter
  import okwo_status_pkg::*;
#(
  parameter int unsigned Width = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  cnt_mode_e        mode_i,
  input  logic [Width-1:0] sub_i,
  input  logic             rep_ovf_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output logic [Width-1:0] count_d_o,
  output logic             ovf_o,
  output logic             ovf_d_o
);

  localparam logic [Width-1:0] MaxVal = {Width{1'b1}};

  logic [Width-1:0] count_q, count_d, after_sub;
  logic             ovf_q, ovf_d;

  assign after_sub = count_q - sub_i;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case (mode_i)
      ModeClear: begin
        count_d = Width'(inc_i);
        ovf_d   = 1'b0;
      end
      ModeRead: begin
        count_d = Width'(sat_add_sub(32'(count_q), 32'(sub_i), inc_i, 32'(MaxVal)));
        ovf_d   = (ovf_q & ~rep_ovf_i) | (inc_i && (after_sub == MaxVal));
      end
      default: begin
        count_d = Width'(sat_add_sub(32'(count_q), 32'd0, inc_i, 32'(MaxVal)));
        ovf_d   = ovf_q | (inc_i && (count_q == MaxVal));
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;
  assign ovf_o     = ovf_q;
  assign ovf_d_o   = ovf_d;

endmodule

// File: rtl/okwo_event_status.sv
// Sticky event word, saturating event counter and overflow flag packed into a
// registered Wire Out status word with lossless clear-on-read.
module okwo_event_status
  import okwo_status_pkg::*;
#(
  parameter int unsigned NUM_EVENTS    = 16,
  parameter int unsigned CNT_WIDTH     = 15,
  parameter int unsigned CLEAR_ON_READ = 1
) (
  input  logic                  ti_clk,
  input  logic                  ti_reset,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic [NUM_EVENTS-1:0] event_mask,
  input  logic                  update_stb,
  input  logic                  clear_stb,
  output logic [31:0]           ep_datain,
  output logic                  irq
);

  if (NUM_EVENTS + CNT_WIDTH + 1 != STATUS_W) begin : g_bad_width
    $error("okwo_event_status: NUM_EVENTS + CNT_WIDTH + 1 must equal 32");
  end

  logic [NUM_EVENTS-1:0] event_q, sticky_q, sticky_d, new_ev, rep_sticky;
  logic [CNT_WIDTH-1:0]  rep_count, count_d;
  logic [31:0]           ep_q, ep_d;
  logic                  armed_q, irq_q, irq_d, inc, rep_ovf, ovf_d;
  cnt_mode_e             mode;

  // Held-high inputs at reset release must not look like fresh edges.
  assign new_ev = armed_q ? (event_in & ~event_q & ~event_mask) : '0;
  assign inc    = |new_ev;

  assign rep_sticky = ep_q[NUM_EVENTS-1:0];
  assign rep_count  = ep_q[OVF_BIT-1:NUM_EVENTS];
  assign rep_ovf    = ep_q[OVF_BIT];

  always_comb begin
    mode     = ModeHold;
    sticky_d = sticky_q | new_ev;
    if (clear_stb) begin
      mode     = ModeClear;
      sticky_d = new_ev;
    end else if (update_stb && (CLEAR_ON_READ != 0)) begin
      mode     = ModeRead;
      sticky_d = (sticky_q & ~rep_sticky) | new_ev;
    end
  end

  okwo_sat_counter #(
    .Width (CNT_WIDTH)
  ) u_counter (
    .clk_i     (ti_clk),
    .rst_i     (ti_reset),
    .mode_i    (mode),
    .sub_i     (rep_count),
    .rep_ovf_i (rep_ovf),
    .inc_i     (inc),
    .count_o   (),
    .count_d_o (count_d),
    .ovf_o     (),
    .ovf_d_o   (ovf_d)
  );

  assign ep_d  = {ovf_d, count_d, sticky_d};
  assign irq_d = (|sticky_d) | ovf_d;

  always_ff @(posedge ti_clk or posedge ti_reset) begin
    if (ti_reset) begin
      armed_q  <= 1'b0;
      event_q  <= '0;
      sticky_q <= '0;
      ep_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      armed_q  <= 1'b1;
      event_q  <= event_in;
      sticky_q <= sticky_d;
      ep_q     <= ep_d;
      irq_q    <= irq_d;
    end
  end

  assign ep_datain = ep_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_okwo_event_status.sv
// Directed bench for okwo_event_status: clear-on-read and hold-only builds.
module tb_okwo_event_status;

  logic        ti_clk = 1'b0;
  logic        ti_reset;
  logic [15:0] event_in, event_mask;
  logic        update_stb, clear_stb;
  logic [31:0] ep_datain;
  logic        irq;

  logic [15:0] b_event;
  logic        b_update, b_clear;
  logic [31:0] b_datain;
  logic        b_irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic flip = 1'b0;

  okwo_event_status #(
    .NUM_EVENTS    (16),
    .CNT_WIDTH     (15),
    .CLEAR_ON_READ (1)
  ) dut (
    .ti_clk     (ti_clk),
    .ti_reset   (ti_reset),
    .event_in   (event_in),
    .event_mask (event_mask),
    .update_stb (update_stb),
    .clear_stb  (clear_stb),
    .ep_datain  (ep_datain),
    .irq        (irq)
  );

  okwo_event_status #(
    .NUM_EVENTS    (16),
    .CNT_WIDTH     (15),
    .CLEAR_ON_READ (0)
  ) dut_hold (
    .ti_clk     (ti_clk),
    .ti_reset   (ti_reset),
    .event_in   (b_event),
    .event_mask (16'h0000),
    .update_stb (b_update),
    .clear_stb  (b_clear),
    .ep_datain  (b_datain),
    .irq        (b_irq)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge ti_clk);
    #1;
  endtask

  initial begin
    ti_reset = 1'b1;
    event_in = '0; event_mask = '0; update_stb = 1'b0; clear_stb = 1'b0;
    b_event = '0; b_update = 1'b0; b_clear = 1'b0;
    #1;
    check("reset_ep", ep_datain, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    repeat (2) step();
    ti_reset = 1'b0;
    repeat (2) step();
    check("idle_ep", ep_datain, 32'h0);

    // single-cycle pulse on bit 3
    event_in = 16'h0008;
    step();
    check("pulse3_ep", ep_datain, 32'h0001_0008);
    check("pulse3_irq", 32'(irq), 32'h1);
    event_in = 16'h0000;
    step();
    check("pulse3_hold", ep_datain, 32'h0001_0008);

    clear_stb = 1'b1;
    step();
    clear_stb = 1'b0;
    check("clear_ep", ep_datain, 32'h0);
    check("clear_irq", 32'(irq), 32'h0);

    // held-high input is one event; masked edge is ignored
    event_in = 16'h0001;
    repeat (10) step();
    check("held_ep", ep_datain, 32'h0001_0001);
    event_in = 16'h0000;
    step();
    event_mask = 16'h0001;
    event_in   = 16'h0001;
    step();
    check("masked_ep", ep_datain, 32'h0001_0001);
    event_mask = 16'h0000;
    event_in   = 16'h0000;
    step();

    // read with a simultaneous new event
    event_in = 16'h0008;
    step();
    event_in = 16'h0009;
    step();
    check("pre_read_ep", ep_datain, 32'h0003_0009);
    update_stb = 1'b1;
    event_in   = 16'h000B;
    step();
    update_stb = 1'b0;
    check("read_new_ep", ep_datain, 32'h0001_0002);
    step();
    check("read_keep_ep", ep_datain, 32'h0001_0002);

    // saturation and overflow
    clear_stb = 1'b1;
    step();
    clear_stb = 1'b0;
    event_in  = 16'h0000;
    step();
    check("sat_start_ep", ep_datain, 32'h0);
    for (int i = 0; i < 32767; i++) begin
      event_in = flip ? 16'hAAAA : 16'h5555;
      flip = ~flip;
      step();
    end
    check("sat_max_ep", ep_datain, 32'h7FFF_FFFF);
    event_in = flip ? 16'hAAAA : 16'h5555;
    flip = ~flip;
    step();
    check("ovf_ep", ep_datain, 32'hFFFF_FFFF);
    check("ovf_irq", 32'(irq), 32'h1);
    for (int i = 0; i < 5; i++) begin
      event_in = flip ? 16'hAAAA : 16'h5555;
      flip = ~flip;
      step();
    end
    check("ovf_sat_ep", ep_datain, 32'hFFFF_FFFF);
    update_stb = 1'b1;
    step();
    update_stb = 1'b0;
    check("ovf_read_ep", ep_datain, 32'h0);
    check("ovf_read_irq", 32'(irq), 32'h0);

    // clear and update together with an edge on bit 5
    event_in = 16'h0000;
    step();
    event_in = 16'h0004;
    step();
    check("pre_clr_ep", ep_datain, 32'h0001_0004);
    clear_stb  = 1'b1;
    update_stb = 1'b1;
    event_in   = 16'h0024;
    step();
    clear_stb  = 1'b0;
    update_stb = 1'b0;
    check("clr_upd_ep", ep_datain, 32'h0001_0020);
    step();

    // asynchronous reset between edges, inputs held high across release
    @(posedge ti_clk);
    #3 ti_reset = 1'b1;
    #1;
    check("async_rst_ep", ep_datain, 32'h0);
    check("async_rst_irq", 32'(irq), 32'h0);
    step();
    ti_reset = 1'b0;
    step();
    check("rel_ep", ep_datain, 32'h0);
    step();
    check("rel_hold_ep", ep_datain, 32'h0);
    check("rel_irq", 32'(irq), 32'h0);

    // hold-only build: update_stb changes nothing
    b_event = 16'h0001;
    step();
    b_event = 16'h0003;
    step();
    check("hold_pre_ep", b_datain, 32'h0002_0003);
    b_update = 1'b1;
    step();
    b_update = 1'b0;
    check("hold_upd_ep", b_datain, 32'h0002_0003);
    check("hold_upd_irq", 32'(b_irq), 32'h1);
    b_clear = 1'b1;
    step();
    b_clear = 1'b0;
    check("hold_clr_ep", b_datain, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
